match_referee: RTL



---
 rtl/match_referee.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/match_referee.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// match_referee
//   Runs the whole match flow for the two-player fighter. It applies typed
//   damage from the hit detector, keeps health saturating, gives each player
//   an invulnerability window after a hit, runs the round timer, scores rounds
//   and ends the match after ROUNDS_TO_WIN round wins.
//
//   Optional build macro SUDDEN_DEATH_EN: a timeout with equal health keeps
//   the round going. The first damage event then decides it, and the damaged
//   player loses. Without the macro a tied timeout is a draw.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   tick              one-cycle frame pulse
//   start             begin match (only seen in IDLE / MATCH_OVER)
//   p1_hit, p2_hit    hit flags, bit0 basic, bit1 directional (level)
//   p1/p2_health      health counters
//   p1/p2_rounds      round wins
//   timer             seconds remaining in the round
//   phase             0 IDLE, 1 FIGHT, 2 KO, 3 MATCH_OVER
//   winner            00 none, 01 P1, 10 P2, 11 draw
//   freeze            high whenever phase != FIGHT
//   round_reset       one-cycle pulse on every entry to FIGHT
// ---------------------------------------------------------------------------
module match_referee #(
    parameter int HEALTH_W      = 4,
    parameter int MAX_HEALTH    = 5,
    parameter int BASIC_DMG     = 1,
    parameter int DIR_DMG       = 2,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int ROUND_W       = 2,
    parameter int ROUND_TIME    = 60,
    parameter int TIME_W        = 7,
    parameter int TICKS_PER_SEC = 60,
    parameter int INVULN_TICKS  = 30,
    parameter int KO_HOLD_TICKS = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic [1:0]          p1_hit,
    input  logic [1:0]          p2_hit,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic [ROUND_W-1:0]  p1_rounds,
    output logic [ROUND_W-1:0]  p2_rounds,
    output logic [TIME_W-1:0]   timer,
    output logic [1:0]          phase,
    output logic [1:0]          winner,
    output logic                freeze,
    output logic                round_reset
);

    localparam int INV_W  = (INVULN_TICKS  > 0) ? $clog2(INVULN_TICKS + 1) : 1;
    localparam int SUB_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC)    : 1;
    localparam int HOLD_W = (KO_HOLD_TICKS > 1) ? $clog2(KO_HOLD_TICKS)    : 1;

    localparam logic [HEALTH_W-1:0] MAX_H_V   = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] BASIC_V   = HEALTH_W'(BASIC_DMG);
    localparam logic [HEALTH_W-1:0] DIR_V     = HEALTH_W'(DIR_DMG);
    localparam logic [ROUND_W-1:0]  RTW_V     = ROUND_W'(ROUNDS_TO_WIN);
    localparam logic [TIME_W-1:0]   TIME_V    = TIME_W'(ROUND_TIME);
    localparam logic [SUB_W-1:0]    SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [INV_W-1:0]    INV_V     = INV_W'(INVULN_TICKS);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(KO_HOLD_TICKS - 1);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_FIGHT = 2'd1,
        PH_KO    = 2'd2,
        PH_OVER  = 2'd3
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [HEALTH_W-1:0] h1_q, h1_d, h2_q, h2_d;
    logic [ROUND_W-1:0]  r1_q, r1_d, r2_q, r2_d;
    logic [TIME_W-1:0]   timer_q, timer_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [INV_W-1:0]    inv1_q, inv1_d, inv2_q, inv2_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          winner_q, winner_d;
    logic                freeze_q, freeze_d;
    logic                rr_q, rr_d;

    // Saturating damage: a hit never wraps health below zero.
    function automatic logic [HEALTH_W-1:0] take_hit(input logic [HEALTH_W-1:0] h,
                                                     input logic [1:0]          hit);
        logic [HEALTH_W-1:0] dmg;
        dmg = hit[1] ? DIR_V : BASIC_V;
        return (h <= dmg) ? '0 : h - dmg;
    endfunction

    function automatic logic [1:0] decide(input logic [HEALTH_W-1:0] a,
                                          input logic [HEALTH_W-1:0] b);
        if (a > b)      return WIN_P1;
        else if (b > a) return WIN_P2;
        else            return WIN_DRAW;
    endfunction

    logic       go_fight;   // enter FIGHT this cycle (round setup below)
    logic       round_end;  // leave FIGHT this cycle with result rw
    logic [1:0] rw;
    logic       sudden;     // tied timeout still being fought out
    logic       land1, land2;

    always_comb begin
        phase_d   = phase_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        timer_d   = timer_q;
        sub_d     = sub_q;
        inv1_d    = inv1_q;
        inv2_d    = inv2_q;
        hold_d    = hold_q;
        winner_d  = winner_q;
        rr_d      = 1'b0;
        go_fight  = 1'b0;
        round_end = 1'b0;
        rw        = WIN_NONE;
        sudden    = 1'b0;
        land1     = 1'b0;
        land2     = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                if (start) go_fight = 1'b1;
            end

            PH_FIGHT: begin
`ifdef SUDDEN_DEATH_EN
                sudden = (timer_q == '0) && (h1_q == h2_q) && (h1_q != '0);
`endif
                // End-of-round test uses the registered state. Hits that
                // arrive on the deciding cycle are dropped.
                if ((h1_q == '0) || (h2_q == '0) || ((timer_q == '0) && !sudden)) begin
                    round_end = 1'b1;
                    rw        = decide(h1_q, h2_q);
                end else begin
                    // During sudden death invulnerability is ignored.
                    land1 = (p1_hit != 2'b00) && ((inv1_q == '0) || sudden);
                    land2 = (p2_hit != 2'b00) && ((inv2_q == '0) || sudden);

                    if (land1) begin
                        h1_d   = take_hit(h1_q, p1_hit);
                        inv1_d = INV_V;
                    end else if (tick && (inv1_q != '0)) begin
                        inv1_d = inv1_q - 1'b1;
                    end

                    if (land2) begin
                        h2_d   = take_hit(h2_q, p2_hit);
                        inv2_d = INV_V;
                    end else if (tick && (inv2_q != '0)) begin
                        inv2_d = inv2_q - 1'b1;
                    end

                    if (tick) begin
                        if (sub_q == SUB_LAST) begin
                            sub_d = '0;
                            if (timer_q != '0) timer_d = timer_q - 1'b1;
                        end else begin
                            sub_d = sub_q + 1'b1;
                        end
                    end

                    // First landed hit in sudden death decides the round.
                    // The damaged player loses.
                    if (sudden && (land1 || land2)) begin
                        round_end = 1'b1;
                        rw        = (land1 && land2) ? WIN_DRAW : (land1 ? WIN_P2 : WIN_P1);
                    end
                end
            end

            PH_KO: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (r1_q == RTW_V) begin
                            phase_d  = PH_OVER;
                            winner_d = WIN_P1;
                        end else if (r2_q == RTW_V) begin
                            phase_d  = PH_OVER;
                            winner_d = WIN_P2;
                        end else begin
                            go_fight = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            PH_OVER: begin
                if (start) begin
                    r1_d     = '0;
                    r2_d     = '0;
                    go_fight = 1'b1;
                end
            end

            default: phase_d = PH_IDLE;
        endcase

        if (round_end) begin
            phase_d  = PH_KO;
            hold_d   = '0;
            winner_d = rw;
            if ((rw == WIN_P1) && (r1_q != RTW_V)) r1_d = r1_q + 1'b1;
            if ((rw == WIN_P2) && (r2_q != RTW_V)) r2_d = r2_q + 1'b1;
        end

        if (go_fight) begin
            phase_d  = PH_FIGHT;
            h1_d     = MAX_H_V;
            h2_d     = MAX_H_V;
            timer_d  = TIME_V;
            sub_d    = '0;
            inv1_d   = '0;
            inv2_d   = '0;
            hold_d   = '0;
            winner_d = WIN_NONE;
            rr_d     = 1'b1;
        end

        freeze_d = (phase_d != PH_FIGHT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_IDLE;
            h1_q     <= MAX_H_V;
            h2_q     <= MAX_H_V;
            r1_q     <= '0;
            r2_q     <= '0;
            timer_q  <= TIME_V;
            sub_q    <= '0;
            inv1_q   <= '0;
            inv2_q   <= '0;
            hold_q   <= '0;
            winner_q <= WIN_NONE;
            freeze_q <= 1'b1;
            rr_q     <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            timer_q  <= timer_d;
            sub_q    <= sub_d;
            inv1_q   <= inv1_d;
            inv2_q   <= inv2_d;
            hold_q   <= hold_d;
            winner_q <= winner_d;
            freeze_q <= freeze_d;
            rr_q     <= rr_d;
        end
    end

    assign p1_health   = h1_q;
    assign p2_health   = h2_q;
    assign p1_rounds   = r1_q;
    assign p2_rounds   = r2_q;
    assign timer       = timer_q;
    assign phase       = phase_q;
    assign winner      = winner_q;
    assign freeze      = freeze_q;
    assign round_reset = rr_q;

endmodule
